seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000: clock cycles each digit is driven (legal 2..65535).
REQ-002 SHALL have parameter GUARD, default 2: all-digits-off cycles between consecutive digits (legal 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  1 = scan display, 0 = display off.
REQ-007 load  input  1  single-cycle request to update displayed value.
REQ-008 load_data  input  16  four BCD nibbles; [3:0] = digit 0 (least significant) ... [15:12] = digit 3.
REQ-009 blank_lz  input  1  1 = suppress leading-zero digits.
REQ-010 bcd_out  output  4  nibble for current digit, feeds the BCD-to-7-segment decoder.
REQ-011 digit_sel  output  4  one-hot active-high digit enable; bit n = digit n.
REQ-012 load_ack  output  1  one-cycle pulse when a loaded value becomes displayed.

Function
REQ-013 SHALL implement states OFF, ON, GAP, plus a 2-bit digit index idx, a 16-bit prescaler, and an 8-bit guard counter.
REQ-014 OFF: digit_sel = 0; go to ON with idx = 0 and prescaler = 0 on the cycle after enable is sampled 1.
REQ-015 ON: digit_sel = one-hot(idx) unless idx is blanked (REQ-020), in which case digit_sel = 0; bcd_out = disp[idx].
REQ-016 ON: prescaler increments each cycle; at REFRESH_DIV-1, clear prescaler and go to GAP with guard counter = 0.
REQ-017 GAP: digit_sel = 0; at guard count GUARD-1, increment idx (3 wraps to 0) and go to ON.
REQ-018 enable sampled 0 in any state: go to OFF next cycle; idx, prescaler, and guard counter clear; disp retained.
REQ-019 bcd_out SHALL be registered, change only on entry to ON, and hold its value in GAP and OFF.
REQ-020 blank_lz = 1: digit n (n = 3, 2, 1) is blanked when disp[n] and all higher nibbles are 0; digit 0 is never blanked.
REQ-021 load = 1: load_data captured into pend, pend_valid set; a load while pend_valid = 1 overwrites pend and yields only one ack.
REQ-022 In OFF, pend SHALL be applied to disp on the cycle after capture.
REQ-023 Otherwise pend SHALL be applied only on the GAP-to-ON transition where idx wraps 3 to 0, giving frame-coherent updates.
REQ-024 load_ack SHALL pulse 1 on the cycle after disp is updated from pend; pend_valid clears on the same cycle as that update.
REQ-025 load coinciding with the apply edge: the old pend is applied and acked; the new data becomes pend, pend_valid stays 1.
REQ-026 Nibbles 10-15 SHALL pass to bcd_out unchanged; a nibble is not zero for blanking unless it equals 0.
REQ-027 At most one digit_sel bit SHALL be 1 in any cycle.

Reset
REQ-028 While reset_n = 0: state = OFF; digit_sel = 0; bcd_out = 0; load_ack = 0; idx, prescaler, guard counter = 0; disp = 0; pend = 0; pend_valid = 0.
REQ-029 Reset asserted mid-scan or mid-GAP SHALL clear outputs immediately (asynchronous) and discard any pending load without ack.
REQ-030 After reset_n rises, first state change SHALL occur on the first rising edge with enable = 1.

Verification (REFRESH_DIV = 4, GUARD = 2)
REQ-031 Bench: enable = 1, load 16'h1234 in OFF.
  -> load_ack pulse.
  -> digit_sel sequence 0001 x4, 0000 x2, 0010 x4, 0000 x2, 0100 x4, 0000 x2, 1000 x4, then repeats.
  -> bcd_out = 4, 3, 2, 1 respectively.
REQ-032 Bench: blank_lz = 1, disp = 16'h0050.
  -> digit_sel is 0 during idx 3 and idx 2 slots; idx 1 shows bcd_out 5; idx 0 shows bcd_out 0 with 0001.
REQ-033 Bench: mid-frame (idx 1) load 16'hAAAA, then load 16'h9876 two cycles later.
  -> display unchanged until idx wraps to 0.
  -> then shows 6, 7, 8, 9 with a single load_ack.
REQ-034 Bench: enable dropped during GAP.
  -> next cycle digit_sel = 0 and OFF.
  -> re-enable restarts at idx 0 with the prior value.
REQ-035 Bench: reset_n pulsed low during ON with pend_valid = 1.
  -> outputs 0 same cycle; no load_ack after release; disp = 0.
REQ-036 Bench: free-run 1000 cycles with random enable/load.
  -> assertion holds that digit_sel is one-hot-or-zero and load_ack never exceeds one cycle.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_ctrl
//  Description : Four-digit multiplexed BCD display scanner with guard gaps,
//                leading-zero blanking and frame-coherent value updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned GUARD       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_sel,
    output logic        load_ack
);

    localparam logic [15:0] c_PRESC_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [7:0]  c_GUARD_LAST = 8'(GUARD - 1);

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_presc;
    logic [7:0]  r_guard;
    logic [15:0] r_disp;
    logic [15:0] r_pend;
    logic        r_pend_valid;
    logic        r_apply_d;
    logic [3:0]  r_bcd;
    logic [3:0]  r_digit_sel;
    logic        r_load_ack;

    logic        w_wrap;
    logic        w_apply;
    logic [15:0] w_disp_next;
    logic [1:0]  w_entry_idx;
    logic        w_z3;
    logic        w_z2;
    logic        w_z1;
    logic [3:0]  w_blank;
    logic [3:0]  w_entry_sel;
    logic [3:0]  w_entry_bcd;

    // Pending values only land on the edge that starts a new frame at digit 0.
    assign w_wrap      = (r_state == ST_GAP) && enable &&
                         (r_guard == c_GUARD_LAST) && (r_idx == 2'd3);
    assign w_apply     = r_pend_valid && ((r_state == ST_OFF) || w_wrap);
    assign w_disp_next = w_apply ? r_pend : r_disp;

    // Digit about to be entered: idx+1 from a gap, digit 0 from OFF.
    assign w_entry_idx = (r_state == ST_GAP) ? (r_idx + 2'd1) : 2'd0;

    assign w_z3    = (w_disp_next[15:12] == 4'd0);
    assign w_z2    = (w_disp_next[11:8]  == 4'd0);
    assign w_z1    = (w_disp_next[7:4]   == 4'd0);
    assign w_blank = {blank_lz & w_z3,
                      blank_lz & w_z3 & w_z2,
                      blank_lz & w_z3 & w_z2 & w_z1,
                      1'b0};

    assign w_entry_sel = w_blank[w_entry_idx] ? 4'd0 : (4'd1 << w_entry_idx);
    assign w_entry_bcd = w_disp_next[{w_entry_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_OFF;
            r_idx        <= 2'd0;
            r_presc      <= 16'd0;
            r_guard      <= 8'd0;
            r_disp       <= 16'd0;
            r_pend       <= 16'd0;
            r_pend_valid <= 1'b0;
            r_apply_d    <= 1'b0;
            r_bcd        <= 4'd0;
            r_digit_sel  <= 4'd0;
            r_load_ack   <= 1'b0;
        end else begin
            r_apply_d  <= w_apply;
            r_load_ack <= r_apply_d;

            if (w_apply) begin
                r_disp <= r_pend;
            end

            // A load on the apply edge becomes the next pending value.
            if (load) begin
                r_pend       <= load_data;
                r_pend_valid <= 1'b1;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end

            if (!enable) begin
                r_state     <= ST_OFF;
                r_idx       <= 2'd0;
                r_presc     <= 16'd0;
                r_guard     <= 8'd0;
                r_digit_sel <= 4'd0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state     <= ST_ON;
                        r_idx       <= 2'd0;
                        r_presc     <= 16'd0;
                        r_guard     <= 8'd0;
                        r_digit_sel <= w_entry_sel;
                        r_bcd       <= w_entry_bcd;
                    end
                    ST_ON: begin
                        if (r_presc == c_PRESC_LAST) begin
                            r_presc     <= 16'd0;
                            r_guard     <= 8'd0;
                            r_state     <= ST_GAP;
                            r_digit_sel <= 4'd0;
                        end else begin
                            r_presc <= r_presc + 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (r_guard == c_GUARD_LAST) begin
                            r_guard     <= 8'd0;
                            r_idx       <= w_entry_idx;
                            r_state     <= ST_ON;
                            r_digit_sel <= w_entry_sel;
                            r_bcd       <= w_entry_bcd;
                        end else begin
                            r_guard <= r_guard + 8'd1;
                        end
                    end
                    default: begin
                        r_state     <= ST_OFF;
                        r_idx       <= 2'd0;
                        r_presc     <= 16'd0;
                        r_guard     <= 8'd0;
                        r_digit_sel <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bcd_out   = r_bcd;
    assign digit_sel = r_digit_sel;
    assign load_ack  = r_load_ack;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_ctrl
//  Description : Directed and random checks of the display scanner against a
//                time-position model of the scan frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int c_RD    = 4;
    localparam int c_GD    = 2;
    localparam int c_SLOT  = c_RD + c_GD;
    localparam int c_FRAME = 4 * c_SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_data = 16'd0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        load_ack;

    int n_tests = 0;
    int n_fail  = 0;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (c_RD),
        .GUARD       (c_GD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .load      (load),
        .load_data (load_data),
        .blank_lz  (blank_lz),
        .bcd_out   (bcd_out),
        .digit_sel (digit_sel),
        .load_ack  (load_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-derived frame for REFRESH_DIV=4, GUARD=2 showing 16'h1234.
    logic [3:0] lit_sel [24] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic [3:0] lit_bcd [24] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4,
                                 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3,
                                 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
                                 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};

    // Model: scanning is a cycle count k since enable; slot = k / SLOT,
    // lit while (k mod SLOT) < REFRESH_DIV.
    bit          m_on;
    int          m_k;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    bit          m_ack_d;
    logic        m_ack;
    logic [3:0]  m_bcd;
    logic [3:0]  m_sel;
    logic [3:0]  m_slot_sel;

    always @(posedge clk or negedge reset_n) begin : model_p
        logic [15:0] nd;
        logic [3:0]  ss;
        bit          app;
        bit          non;
        int          nk;
        int          s;
        if (!reset_n) begin
            m_on       <= 1'b0;
            m_k        <= 0;
            m_disp     <= 16'd0;
            m_pend     <= 16'd0;
            m_pv       <= 1'b0;
            m_ack_d    <= 1'b0;
            m_ack      <= 1'b0;
            m_bcd      <= 4'd0;
            m_sel      <= 4'd0;
            m_slot_sel <= 4'd0;
        end else begin
            app = m_pv && (!m_on || (enable && (m_k % c_FRAME) == c_FRAME - 1));
            nd  = app ? m_pend : m_disp;
            m_ack   <= m_ack_d;
            m_ack_d <= app;
            m_disp  <= nd;
            if (load) begin
                m_pend <= load_data;
                m_pv   <= 1'b1;
            end else if (app) begin
                m_pv <= 1'b0;
            end
            if (!enable) begin
                non = 1'b0;
                nk  = 0;
            end else if (!m_on) begin
                non = 1'b1;
                nk  = 0;
            end else begin
                non = 1'b1;
                nk  = m_k + 1;
            end
            m_on <= non;
            m_k  <= nk;
            ss = m_slot_sel;
            if (non && (nk % c_SLOT) == 0) begin
                s = (nk / c_SLOT) % 4;
                m_bcd <= nd[4*s +: 4];
                ss = (blank_lz && s != 0 && (nd >> (4*s)) == 16'd0) ? 4'd0 : (4'd1 << s);
                m_slot_sel <= ss;
            end
            m_sel <= (non && (nk % c_SLOT) < c_RD) ? ss : 4'd0;
        end
    end

    bit   chk_on = 1'b0;
    logic prev_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("model digit_sel", {12'd0, digit_sel}, {12'd0, m_sel});
            check("model bcd_out",   {12'd0, bcd_out},   {12'd0, m_bcd});
            check("model load_ack",  {15'd0, load_ack},  {15'd0, m_ack});
            check("digit_sel onehot0", {15'd0, $onehot0(digit_sel)}, 16'd1);
            check("load_ack one cycle", {15'd0, load_ack & prev_ack}, 16'd0);
            prev_ack = load_ack;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acks;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        check("reset digit_sel", {12'd0, digit_sel}, 16'd0);
        check("reset bcd_out",   {12'd0, bcd_out},   16'd0);
        check("reset load_ack",  {15'd0, load_ack},  16'd0);

        // Load in OFF, then scan 16'h1234 for two frames.
        load = 1'b1; load_data = 16'h1234;
        @(negedge clk); load = 1'b0;
        @(negedge clk); check("off load ack early", {15'd0, load_ack}, 16'd0);
        @(negedge clk); check("off load ack pulse", {15'd0, load_ack}, 16'd1);
        @(negedge clk); check("off load ack end",   {15'd0, load_ack}, 16'd0);
        enable = 1'b1;
        for (int i = 0; i < 2 * c_FRAME; i++) begin
            @(negedge clk);
            check("frame1234 digit_sel", {12'd0, digit_sel}, {12'd0, lit_sel[i % c_FRAME]});
            check("frame1234 bcd_out",   {12'd0, bcd_out},   {12'd0, lit_bcd[i % c_FRAME]});
        end

        // Leading-zero blanking of 16'h0050.
        enable = 1'b0; blank_lz = 1'b1; load = 1'b1; load_data = 16'h0050;
        @(negedge clk); load = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0 || i == 24) begin
                check("blank idx0 sel", {12'd0, digit_sel}, 16'h0001);
                check("blank idx0 bcd", {12'd0, bcd_out},   16'h0000);
            end
            if (i == 6) begin
                check("blank idx1 sel", {12'd0, digit_sel}, 16'h0002);
                check("blank idx1 bcd", {12'd0, bcd_out},   16'h0005);
            end
            if (i == 12) check("blank idx2 sel", {12'd0, digit_sel}, 16'h0000);
            if (i == 18) check("blank idx3 sel", {12'd0, digit_sel}, 16'h0000);
        end

        // Mid-frame double load: only the second value shows, once, at the wrap.
        enable = 1'b0; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (load_ack) acks++;
            if (i == 6)  check("midframe idx1 old", {12'd0, bcd_out}, 16'h0005);
            if (i == 12) check("midframe idx2 old", {12'd0, bcd_out}, 16'h0000);
            if (i == 18) begin
                check("midframe idx3 old", {12'd0, bcd_out},   16'h0000);
                check("midframe idx3 sel", {12'd0, digit_sel}, 16'h0008);
            end
            if (i == 24) check("newframe idx0", {12'd0, bcd_out}, 16'h0006);
            if (i == 30) check("newframe idx1", {12'd0, bcd_out}, 16'h0007);
            if (i == 36) check("newframe idx2", {12'd0, bcd_out}, 16'h0008);
            if (i == 42) check("newframe idx3", {12'd0, bcd_out}, 16'h0009);
            if (i == 7)  begin load = 1'b1; load_data = 16'hAAAA; end
            if (i == 8)  load = 1'b0;
            if (i == 9)  begin load = 1'b1; load_data = 16'h9876; end
            if (i == 10) load = 1'b0;
        end
        check("midframe single ack", 16'(acks), 16'd1);

        // Enable dropped during a gap, then re-enabled.
        repeat (3) @(negedge clk);
        check("gap before drop sel", {12'd0, digit_sel}, 16'h0000);
        check("gap before drop bcd", {12'd0, bcd_out},   16'h0006);
        enable = 1'b0;
        @(negedge clk);
        check("drop sel off", {12'd0, digit_sel}, 16'h0000);
        check("drop bcd hold", {12'd0, bcd_out},  16'h0006);
        repeat (3) @(negedge clk);
        check("off sel stays", {12'd0, digit_sel}, 16'h0000);
        enable = 1'b1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("reenable idx0 sel", {12'd0, digit_sel}, 16'h0001);
                check("reenable idx0 bcd", {12'd0, bcd_out},   16'h0006);
            end
            if (j == 6) begin
                check("reenable idx1 sel", {12'd0, digit_sel}, 16'h0002);
                check("reenable idx1 bcd", {12'd0, bcd_out},   16'h0007);
            end
            if (j == 7) begin load = 1'b1; load_data = 16'h5555; end
            if (j == 8) load = 1'b0;
        end

        // Asynchronous reset mid-ON with a pending load.
        #2 reset_n = 1'b0;
        #1;
        check("async reset sel", {12'd0, digit_sel}, 16'h0000);
        check("async reset bcd", {12'd0, bcd_out},   16'h0000);
        check("async reset ack", {15'd0, load_ack},  16'h0000);
        repeat (2) @(negedge clk);
        enable  = 1'b0;
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (load_ack) acks++;
        end
        check("post reset no ack", 16'(acks), 16'd0);
        check("post reset idle sel", {12'd0, digit_sel}, 16'h0000);
        enable = 1'b1;
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            if (load_ack) acks++;
            check("post reset sel", {12'd0, digit_sel}, {12'd0, lit_sel[i]});
            check("post reset bcd", {12'd0, bcd_out},   16'h0000);
        end
        check("post reset scan no ack", 16'(acks), 16'd0);

        // Random free-run; the per-cycle compare covers every cycle.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 19) != 0);
            load      = ($urandom_range(0, 9) == 0);
            load_data = 16'($urandom);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
        end
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
